// File: rtl/ahb_bridge_arbiter_pkg.sv
// Shared AHB transfer encodings and arbiter state type for the bridge arbiter.
package ahb_bridge_arbiter_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  typedef enum logic {
    PARK = 1'b0,
    OWN  = 1'b1
  } arb_state_t;

  function automatic logic is_beat(input logic [1:0] trans);
    return (trans == HTRANS_NONSEQ) || (trans == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahb_bridge_arbiter_if.sv
// Request/grant bundle between the AHB requesters and the bridge arbiter.
// Lock signals (Hlock/Hmastlock) exist only when ARB_LOCK_EN is defined.
interface ahb_bridge_arbiter_if #(
  parameter int NUM_MST = 4
);
  import ahb_bridge_arbiter_pkg::*;

  localparam int MW = (NUM_MST > 1) ? $clog2(NUM_MST) : 1;

  // Handshake: a master holds Hbusreq until it sees its Hgrant bit; grant and
  // owner indices only move on an edge where Hreadyin=1, otherwise all hold.
  logic [NUM_MST-1:0] Hbusreq;
  logic [1:0]         Htrans;
  logic               Hreadyin;
  logic [NUM_MST-1:0] Hgrant;
  logic [MW-1:0]      Hmaster;
  logic [MW-1:0]      Hmaster_d;
  arb_state_t         arb_state;
`ifdef ARB_LOCK_EN
  logic [NUM_MST-1:0] Hlock;
  logic               Hmastlock;

  modport master (
    output Hbusreq, Htrans, Hreadyin, Hlock,
    input  Hgrant, Hmaster, Hmaster_d, arb_state, Hmastlock
  );
  modport slave (
    input  Hbusreq, Htrans, Hreadyin, Hlock,
    output Hgrant, Hmaster, Hmaster_d, arb_state, Hmastlock
  );
`else
  modport master (
    output Hbusreq, Htrans, Hreadyin,
    input  Hgrant, Hmaster, Hmaster_d, arb_state
  );
  modport slave (
    input  Hbusreq, Htrans, Hreadyin,
    output Hgrant, Hmaster, Hmaster_d, arb_state
  );
`endif

endinterface

// File: rtl/ahb_bridge_arbiter_rr_picker.sv
// Combinational round-robin pick: first requester strictly after ptr, wrapping.
module ahb_bridge_arbiter_rr_picker #(
  parameter int NUM_MST = 4,
  parameter int MW      = (NUM_MST > 1) ? $clog2(NUM_MST) : 1
) (
  input  logic [NUM_MST-1:0] req_i,
  input  logic [MW-1:0]      ptr_i,
  output logic [NUM_MST-1:0] onehot_o,
  output logic [MW-1:0]      idx_o,
  output logic               any_o
);

  int          cand;
  logic [MW-1:0] cand_idx;

  // The pointer's own slot is searched last, so the current owner only wins
  // again when nobody else is asking.
  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    any_o    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 1; k <= NUM_MST; k++) begin
      cand = int'(ptr_i) + k;
      if (cand >= NUM_MST) cand = cand - NUM_MST;
      cand_idx = MW'(cand);
      if (!any_o && req_i[cand_idx]) begin
        any_o              = 1'b1;
        idx_o              = cand_idx;
        onehot_o[cand_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ahb_bridge_arbiter.sv
// Round-robin address-phase arbiter in front of the AHB-to-APB bridge slave port.
// Optional ARB_LOCK_EN adds Hlock/Hmastlock: a locked owner ignores the beat cap.
module ahb_bridge_arbiter #(
  parameter int NUM_MST   = 4,
  parameter int MAX_BEATS = 16
) (
  input logic                 Hclk,
  input logic                 Hresetn,
  ahb_bridge_arbiter_if.slave bus
);
  import ahb_bridge_arbiter_pkg::*;

  localparam int MW = (NUM_MST > 1) ? $clog2(NUM_MST) : 1;
  localparam int CW = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
  localparam logic [CW-1:0] BEAT_CAP = CW'(MAX_BEATS - 1);

  arb_state_t    state_q, state_d;
  logic [MW-1:0] owner_q, owner_d;
  logic [MW-1:0] owner_dp_q, owner_dp_d;
  logic [MW-1:0] rr_ptr_q, rr_ptr_d;
  logic [CW-1:0] beat_q, beat_d;
`ifdef ARB_LOCK_EN
  logic          lock_q, lock_d;
`endif

  logic [NUM_MST-1:0] grant;
  logic [NUM_MST-1:0] win_oh;
  logic [MW-1:0]      win_idx;
  logic               win_any;
  logic               beat, others, cap_hit, rearb;

  ahb_bridge_arbiter_rr_picker #(
    .NUM_MST (NUM_MST),
    .MW      (MW)
  ) u_picker (
    .req_i    (bus.Hbusreq),
    .ptr_i    (rr_ptr_q),
    .onehot_o (win_oh),
    .idx_o    (win_idx),
    .any_o    (win_any)
  );

  assign grant = {{(NUM_MST-1){1'b0}}, 1'b1} << owner_q;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    owner_dp_d = owner_dp_q;
    rr_ptr_d   = rr_ptr_q;
    beat_d     = beat_q;
`ifdef ARB_LOCK_EN
    lock_d     = lock_q;
`endif
    beat    = is_beat(bus.Htrans);
    others  = |(bus.Hbusreq & ~grant);
    cap_hit = beat && (beat_q == BEAT_CAP) && others;
`ifdef ARB_LOCK_EN
    cap_hit = cap_hit && !bus.Hlock[owner_q];
`endif
    rearb = (state_q == PARK) || !bus.Hbusreq[owner_q] ||
            (bus.Htrans == HTRANS_IDLE) || cap_hit;

    if (bus.Hreadyin) begin
      owner_dp_d = owner_q;
      if (rearb) begin
        beat_d = '0;
        if (win_any) begin
          // win_oh overlapping the grant means the owner re-won: tenure restarts.
          state_d  = OWN;
          owner_d  = win_idx;
          rr_ptr_d = |(win_oh & grant) ? rr_ptr_q : win_idx;
`ifdef ARB_LOCK_EN
          lock_d   = bus.Hlock[win_idx];
`endif
        end else begin
          state_d = PARK;
          owner_d = '0;
`ifdef ARB_LOCK_EN
          lock_d  = 1'b0;
`endif
        end
      end else if (beat && (beat_q != BEAT_CAP)) begin
        beat_d = beat_q + 1'b1;
      end
    end
  end

  always_ff @(posedge Hclk) begin
    if (!Hresetn) begin
      state_q    <= PARK;
      owner_q    <= '0;
      owner_dp_q <= '0;
      rr_ptr_q   <= '0;
      beat_q     <= '0;
`ifdef ARB_LOCK_EN
      lock_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      owner_dp_q <= owner_dp_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_q     <= beat_d;
`ifdef ARB_LOCK_EN
      lock_q     <= lock_d;
`endif
    end
  end

  assign bus.Hgrant    = grant;
  assign bus.Hmaster   = owner_q;
  assign bus.Hmaster_d = owner_dp_q;
  assign bus.arb_state = state_q;
`ifdef ARB_LOCK_EN
  assign bus.Hmastlock = lock_q;
`endif

endmodule
